// File: rtl/ps2_kbd_rx.sv
// Host-side PS/2 keyboard receiver: filtered clock, 11-bit frame deserialiser
// with parity/stop checking, and E0/F0 prefix folding into single key events.
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_strobe,
  output logic [7:0] byte_data,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [3:0]  FL_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_filt;
  logic [3:0]  filt_cnt;
  logic        fall;
  logic        data_bit;
  logic [15:0] to_cnt;
  logic        timeout;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        par_ok;
  logic        ev_ok, ev_perr, ev_ferr;
  logic        ext_flag, rel_flag;

  assign data_bit = data_sync[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FL_LAST) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
      fall <= clk_filt & ~clk_sync[1] & (filt_cnt == FL_LAST);
    end
  end

  // Timeout counter only runs mid-frame; glitches never reach 'fall' so they can't clear it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                    to_cnt <= '0;
    else if (state == S_IDLE || fall) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 16'd1;
  end

  assign timeout = (state != S_IDLE) && !fall && (to_cnt == TO_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (fall && !data_bit)        state_nx = S_DATA;
      S_DATA:   if (fall && bit_cnt == 3'd7)  state_nx = S_PARITY;
      S_PARITY: if (fall)                     state_nx = S_STOP;
      S_STOP:   if (fall)                     state_nx = S_IDLE;
      default:                                state_nx = S_IDLE;
    endcase
    if (timeout) state_nx = S_IDLE;
  end

  always_comb begin
    ev_ok   = 1'b0;
    ev_perr = 1'b0;
    ev_ferr = timeout;
    if (state == S_STOP && fall) begin
      if (!data_bit)   ev_ferr = 1'b1;
      else if (par_ok) ev_ok   = 1'b1;
      else             ev_perr = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
    end else if (fall) begin
      case (state)
        S_IDLE:   bit_cnt <= '0;
        S_DATA: begin
          shreg   <= {data_bit, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_PARITY: par_ok <= ^{shreg, data_bit};
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      byte_strobe <= 1'b0;
      byte_data   <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_strobe <= ev_ok;
      parity_err  <= ev_perr;
      frame_err   <= ev_ferr;
      if (ev_ok) byte_data <= shreg;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_strobe   <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      ext_flag     <= 1'b0;
      rel_flag     <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (parity_err || frame_err) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (byte_strobe) begin
        if (byte_data == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (byte_data == 8'hF0) begin
          rel_flag <= 1'b1;
        end else begin
          key_strobe   <= 1'b1;
          key_code     <= byte_data;
          key_extended <= ext_flag;
          key_released <= rel_flag;
          ext_flag     <= 1'b0;
          rel_flag     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, prefixes, parity/stop/timeout errors, glitch, reset.
module tb_ps2_kbd_rx;

  localparam int HALF    = 100;
  localparam int TIMEOUT = 2000;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       byte_strobe, key_strobe, key_extended, key_released, parity_err, frame_err;
  logic [7:0] byte_data, key_code;

  int errors = 0;
  int checks = 0;

  int n_byte = 0, n_key = 0, n_perr = 0, n_ferr = 0;
  int cyc = 0, byte_cyc = 0, key_cyc = 0;
  logic [7:0] last_byte = '0, last_key = '0;
  logic last_ext = 1'b0, last_rel = 1'b0;

  ps2_kbd_rx #(.FILTER_LEN(4), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_strobe(byte_strobe), .byte_data(byte_data), .key_strobe(key_strobe),
    .key_code(key_code), .key_extended(key_extended), .key_released(key_released),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    cyc++;
    if (byte_strobe) begin n_byte++; last_byte = byte_data; byte_cyc = cyc; end
    if (key_strobe) begin
      n_key++; last_key = key_code; last_ext = key_extended; last_rel = key_released; key_cyc = cyc;
    end
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_cyc(5);
    @(negedge clk_sys);
    checks++; if ({byte_strobe, key_strobe, parity_err, frame_err} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {byte_strobe, key_strobe, parity_err, frame_err}); end
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h expected 00", byte_data); end
    checks++; if ({key_code, key_extended, key_released} !== 10'h0) begin
      errors++; $display("FAIL reset_key: got %h/%b/%b expected 00/0/0", key_code, key_extended, key_released); end
    reset_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_single;
    int b0, k0;
    b0 = n_byte; k0 = n_key;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (n_byte - b0 !== 1) begin errors++; $display("FAIL single_byte_cnt: got %0d expected 1", n_byte - b0); end
    checks++; if (last_byte !== 8'h1C) begin errors++; $display("FAIL single_byte_data: got %h expected 1c", last_byte); end
    checks++; if (n_key - k0 !== 1) begin errors++; $display("FAIL single_key_cnt: got %0d expected 1", n_key - k0); end
    checks++; if ({last_key, last_ext, last_rel} !== {8'h1C, 2'b00}) begin
      errors++; $display("FAIL single_key: got %h/%b/%b expected 1c/0/0", last_key, last_ext, last_rel); end
    checks++; if (key_cyc - byte_cyc !== 1) begin errors++; $display("FAIL key_latency: got %0d expected 1", key_cyc - byte_cyc); end
  endtask

  task automatic test_break;
    int b0, k0;
    b0 = n_byte; k0 = n_key;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (n_byte - b0 !== 2) begin errors++; $display("FAIL break_byte_cnt: got %0d expected 2", n_byte - b0); end
    checks++; if (n_key - k0 !== 1) begin errors++; $display("FAIL break_key_cnt: got %0d expected 1", n_key - k0); end
    checks++; if ({last_key, last_ext, last_rel} !== {8'h1C, 2'b01}) begin
      errors++; $display("FAIL break_key: got %h/%b/%b expected 1c/0/1", last_key, last_ext, last_rel); end
  endtask

  task automatic test_ext_break;
    int k0;
    k0 = n_key;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    checks++; if (n_key - k0 !== 1) begin errors++; $display("FAIL extbrk_key_cnt: got %0d expected 1", n_key - k0); end
    checks++; if ({last_key, last_ext, last_rel} !== {8'h75, 2'b11}) begin
      errors++; $display("FAIL extbrk_key: got %h/%b/%b expected 75/1/1", last_key, last_ext, last_rel); end
    send_frame(8'h75, 1'b0, 1'b1);
    checks++; if ({last_key, last_ext, last_rel} !== {8'h75, 2'b00}) begin
      errors++; $display("FAIL plain_after_prefix: got %h/%b/%b expected 75/0/0", last_key, last_ext, last_rel); end
    k0 = n_key;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1);
    checks++; if (n_key - k0 !== 1 || {last_key, last_ext, last_rel} !== {8'h6B, 2'b10}) begin
      errors++; $display("FAIL repeat_prefix: got %0d %h/%b/%b expected 1 6b/1/0", n_key - k0, last_key, last_ext, last_rel); end
  endtask

  task automatic test_parity;
    int b0, k0, p0;
    send_frame(8'hE0, 1'b0, 1'b1);
    b0 = n_byte; k0 = n_key; p0 = n_perr;
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_err_cnt: got %0d expected 1", n_perr - p0); end
    checks++; if (n_byte - b0 !== 0 || n_key - k0 !== 0) begin
      errors++; $display("FAIL parity_no_strobe: got %0d/%0d expected 0/0", n_byte - b0, n_key - k0); end
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if ({last_key, last_ext, last_rel} !== {8'h1C, 2'b00}) begin
      errors++; $display("FAIL parity_clears_ext: got %h/%b/%b expected 1c/0/0", last_key, last_ext, last_rel); end
  endtask

  task automatic test_timeout;
    int b0, f0;
    b0 = n_byte; f0 = n_ferr;
    send_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT + 10);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL timeout_frame_err: got %0d expected 1", n_ferr - f0); end
    checks++; if (n_byte - b0 !== 0) begin errors++; $display("FAIL timeout_no_byte: got %0d expected 0", n_byte - b0); end
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++; if (n_byte - b0 !== 1 || last_byte !== 8'h5A) begin
      errors++; $display("FAIL after_timeout: got %0d %h expected 1 5a", n_byte - b0, last_byte); end
  endtask

  task automatic test_stop_err;
    int b0, f0, p0;
    b0 = n_byte; f0 = n_ferr; p0 = n_perr;
    send_frame(8'h1C, 1'b1, 1'b0);
    checks++; if (n_ferr - f0 !== 1 || n_perr - p0 !== 0 || n_byte - b0 !== 0) begin
      errors++; $display("FAIL stop_err: got ferr=%0d perr=%0d byte=%0d expected 1 0 0", n_ferr - f0, n_perr - p0, n_byte - b0); end
  endtask

  task automatic test_glitch;
    int b0, f0, p0;
    b0 = n_byte; f0 = n_ferr; p0 = n_perr;
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_data = 1'b1;
    wait_cyc(50);
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (n_byte - b0 !== 1 || last_byte !== 8'h1C) begin
      errors++; $display("FAIL glitch_byte: got %0d %h expected 1 1c", n_byte - b0, last_byte); end
    checks++; if (n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin
      errors++; $display("FAIL glitch_errs: got %0d/%0d expected 0/0", n_ferr - f0, n_perr - p0); end
  endtask

  task automatic test_reset_mid;
    int b0, f0, p0;
    send_bit(1'b0);
    for (int unsigned i = 0; i < 3; i++) send_bit(1'b0);
    reset_n = 1'b0;
    wait_cyc(3);
    @(negedge clk_sys);
    checks++; if ({byte_strobe, byte_data, key_strobe, key_code, key_extended, key_released, parity_err, frame_err} !== 22'h0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h %h expected 00 00", byte_data, key_code); end
    reset_n = 1'b1;
    b0 = n_byte; f0 = n_ferr; p0 = n_perr;
    wait_cyc(TIMEOUT + 100);
    checks++; if (n_byte - b0 !== 0 || n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin
      errors++; $display("FAIL reset_mid_silent: got %0d/%0d/%0d expected 0/0/0", n_byte - b0, n_ferr - f0, n_perr - p0); end
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (n_byte - b0 !== 1 || {last_key, last_ext, last_rel} !== {8'h1C, 2'b00}) begin
      errors++; $display("FAIL reset_mid_recover: got %0d %h/%b/%b expected 1 1c/0/0", n_byte - b0, last_key, last_ext, last_rel); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_break;
    test_ext_break;
    test_parity;
    test_timeout;
    test_stop_err;
    test_glitch;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Host-side PS/2 keyboard receiver for the Apple II core.
- Consumes the ps2_kbd_clk / ps2_kbd_data serial stream produced by the I/O-controller SPI interface. That stream is idle-high; data changes on rising clock and is valid on falling clock.
- Deserialises 11-bit frames and checks parity and stop bit.
- Folds the E0 (extended) and F0 (break) prefixes into single key events for the downstream keyboard-matrix / ASCII translator.

Parameters:
- FILTER_LEN, 4: consecutive equal clk_sys samples required before the filtered PS/2 clock level changes (range 2..15).
- TIMEOUT, 2000: clk_sys cycles without a filtered falling edge while mid-frame before the frame is aborted (16-bit counter).

Ports:
- clk_sys, input, 1: system clock; all logic is on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- ps2_clk, input, 1: PS/2 clock; asynchronous to clk_sys.
- ps2_data, input, 1: PS/2 data; asynchronous to clk_sys.
- byte_strobe, output, 1: one-cycle pulse; a raw byte was received without error.
- byte_data, output, 8: raw received byte; valid while byte_strobe is high, held afterwards.
- key_strobe, output, 1: one-cycle pulse; a complete key event is available.
- key_code, output, 8: scan code of the key event.
- key_extended, output, 1: E0 prefix preceded key_code.
- key_released, output, 1: F0 prefix preceded key_code.
- parity_err, output, 1: one-cycle pulse on an odd-parity failure.
- frame_err, output, 1: one-cycle pulse on a bad stop bit or a timeout.

Behaviour:
- Reset: all outputs are 0, including byte_data and key_code. The state machine is in IDLE. Prefix flags are clear. The filter is initialised to "high". Reset asserted mid-frame discards the partial frame; no strobe or error pulse is produced.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops.
- Clock filter: the filtered clock changes only after FILTER_LEN consecutive synchronised samples of the new level. Data is not filtered.
- Sampling: the data bit is sampled on the cycle a filtered falling edge is detected.
- State machine (frame): IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data 0, go to DATA with bit count 0. A falling edge with data 1 is ignored; stay in IDLE.
  - DATA: shift bits in LSB first; after the 8th bit go to PARITY.
  - PARITY: parity is good if the 8 data bits plus the parity bit contain an odd number of ones. Latch the result and go to STOP.
  - STOP: if the stop bit is 1 and parity was good, byte_strobe=1 and byte_data=byte on the next cycle. If the stop bit is 1 and parity was bad, parity_err=1. If the stop bit is 0, frame_err=1; this takes priority over parity_err. Always return to IDLE.
- Timeout: the counter runs in every state except IDLE and clears on each filtered falling edge. When it reaches TIMEOUT the machine returns to IDLE and pulses frame_err. There is no byte_strobe.
- Prefix decode runs on each byte_strobe:
  - E0 sets the ext flag.
  - F0 sets the rel flag.
  - Any other byte (including E1 and AA) produces key_strobe on the cycle after byte_strobe. key_code = byte, key_extended = ext, key_released = rel. Both flags then clear.
  - Repeated prefixes are idempotent.
- Error handling: any parity_err or frame_err clears both prefix flags. No key_strobe is produced for the errored frame.
- Latency:
  - byte_strobe: 1 clk_sys cycle after the stop-bit filtered edge.
  - key_strobe: 1 cycle after byte_strobe.
  - Filtered edge: 2 + FILTER_LEN cycles after the pin edge.
- Back-to-back frames: no inter-frame gap is required beyond the stop-bit high time. A start falling edge can arrive in the first IDLE cycle.
- Glitches: a clock pulse shorter than FILTER_LEN cycles produces no edge and does not reset the timeout.

Test Plan:
- Send 0x1C: data bits 0,0,1,1,1,0,0,0, parity 0, stop 1, at 100-cycle half-periods → byte_strobe with byte_data=1C. Next cycle key_strobe, key_code=1C, ext=0, rel=0.
- Send F0 then 1C → two byte_strobes and exactly one key_strobe: key_code=1C, rel=1, ext=0.
- Send E0, F0, 75 → one key_strobe: key_code=75, ext=1, rel=1. Then send 75 alone → ext=0, rel=0.
- Send 0x1C with parity bit 1 → parity_err pulse, no byte_strobe. A preceding E0 is discarded: a following 0x1C gives ext=0.
- Send start plus 4 data bits, then hold the clock high for TIMEOUT+10 cycles → exactly one frame_err and a return to IDLE. A following valid 0x5A frame gives byte_data=5A.
- Variant: stop bit 0 → frame_err and no parity_err.
- Inject a 2-cycle low glitch on ps2_clk with FILTER_LEN=4 → no bit sampled.
- Pulse reset_n low mid-DATA → all outputs 0, then a clean 0x1C is received correctly.
